// File: rtl/serpent_sbox_layer_seq.sv
// Sequential Serpent S-box layer: applies forward or inverse S-box k to a
// bitsliced 128-bit block, LANES slices per cycle, with valid/ready on both sides.
module serpent_sbox_layer_seq #(
  parameter int LANES = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_inverse,
  input  logic [2:0]   i_sbox_index,
  input  logic [31:0]  i_word_0,
  input  logic [31:0]  i_word_1,
  input  logic [31:0]  i_word_2,
  input  logic [31:0]  i_word_3,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [31:0]  o_word_0,
  output logic [31:0]  o_word_1,
  output logic [31:0]  o_word_2,
  output logic [31:0]  o_word_3,
  output logic [127:0] o_data
);

  localparam int N  = 32 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16 && LANES != 32) begin : gBadLanes
    $error("serpent_sbox_layer_seq: LANES must be 1, 2, 4, 8, 16 or 32");
  end

  // Forward tables S0..S7, entry x held in bits [4x+3:4x].
  localparam logic [63:0] FwdTab [8] = '{
    64'hC907_24DE_B56A_1F83,
    64'h43D6_8EB1_A509_72CF,
    64'h25B0_4E1D_FAC3_9768,
    64'hE57A_421D_369C_8BF0,
    64'hD7E9_A452_6B0C_38F1,
    64'h176D_8E30_C9A4_B25F,
    64'h0A3D_F19E_B648_5C27,
    64'h6539_AC47_B28E_0FD1
  };

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    in_q, in_d;
  logic [127:0]    out_q, out_d;
  logic            inv_q, inv_d;
  logic [2:0]      idx_q, idx_d;
  logic            load;
  logic            last;

  // The inverse is found by searching the forward table for the matching output.
  function automatic logic [3:0] sbox(input logic inv, input logic [2:0] k, input logic [3:0] x);
    logic [3:0] res;
    logic [3:0] jj;
    res = FwdTab[k][{x, 2'b00} +: 4];
    if (inv) begin
      res = 4'd0;
      for (int j = 0; j < 16; j++) begin
        jj = 4'(j);
        if (FwdTab[k][{jj, 2'b00} +: 4] == x) res = jj;
      end
    end
    return res;
  endfunction

  assign last = (cnt_q == CW'(N - 1));
  assign load = i_valid && ((state_q == IDLE) || (state_q == DONE && i_ready));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_valid) state_d = BUSY;
      BUSY: if (last) state_d = DONE;
      DONE: if (i_ready) state_d = i_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: o_ready = !i_rst;
      DONE: begin
        o_valid = 1'b1;
        o_ready = i_ready && !i_rst;
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [4:0] pos;
    logic [3:0] nib;
    logic [3:0] y;
    in_d  = in_q;
    inv_d = inv_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    out_d = out_q;
    pos   = 5'd0;
    nib   = 4'd0;
    y     = 4'd0;
    if (load) begin
      in_d  = {i_word_3, i_word_2, i_word_1, i_word_0};
      inv_d = i_inverse;
      idx_d = i_sbox_index;
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      for (int l = 0; l < LANES; l++) begin
        pos = 5'(int'(cnt_q) * LANES + l);
        nib = {in_q[{2'd3, pos}], in_q[{2'd2, pos}], in_q[{2'd1, pos}], in_q[{2'd0, pos}]};
        y   = sbox(inv_q, idx_q, nib);
        out_d[{2'd0, pos}] = y[0];
        out_d[{2'd1, pos}] = y[1];
        out_d[{2'd2, pos}] = y[2];
        out_d[{2'd3, pos}] = y[3];
      end
      if (!last) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      in_q  <= '0;
      out_q <= '0;
      inv_q <= 1'b0;
      idx_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      in_q  <= in_d;
      out_q <= out_d;
      inv_q <= inv_d;
      idx_q <= idx_d;
    end
  end

  assign o_data   = out_q;
  assign o_word_0 = out_q[31:0];
  assign o_word_1 = out_q[63:32];
  assign o_word_2 = out_q[95:64];
  assign o_word_3 = out_q[127:96];

endmodule

// File: doc/serpent_sbox_layer_seq.md
# serpent_sbox_layer_seq

Parametrised, sequential Serpent S-box layer: applies one of the eight forward S-boxes or their inverses to a 128-bit bitsliced block (four 32-bit words), processing `LANES` bit slices per cycle. It has valid/ready handshakes on both sides. It is the successor to the purely combinational inverse-only S-box layer. It sits between the key-mixing XOR and the linear transform in both the encryption and decryption round datapaths, and trades area for throughput through `LANES`.

## Interface
- `LANES`, default 8: bit slices evaluated per cycle. Legal values are 1, 2, 4, 8, 16 and 32; any other value is a compile-time error.
- `N` (localparam) = 32/`LANES`: number of processing cycles per block.
- `i_clk`  in  1  single clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  input block present.
- `o_ready`  out  1  block can accept input.
- `i_inverse`  in  1  0 = forward S-box Sk, 1 = inverse S-box Sk⁻¹.
- `i_sbox_index`  in  3  S-box number k, 0..7.
- `i_word_0`..`i_word_3`  in  32 each  input words. Slice i is {w3[i],w2[i],w1[i],w0[i]}, with w0 as the LSB.
- `o_valid`  out  1  result present.
- `i_ready`  in  1  downstream accepts the result.
- `o_word_0`..`o_word_3`  out  32 each  result words. Bit j of the S-box output goes to `o_word_j[i]`.
- `o_data`  out  128  {o_word_3, o_word_2, o_word_1, o_word_0}.

## Operation
- **S-box tables.** Use the Serpent S0–S7 tables from the AES submission. The inverse tables are their exact inverses. For example:
  - S0 = 3 8 15 1 10 6 5 11 14 13 4 2 7 0 9 12
  - S0⁻¹ = 13 3 11 0 10 6 5 12 1 14 4 7 15 9 8 2
- **Evaluation.** One shared 16-entry lookup is instantiated per lane, selected by the captured {inverse, index}. All lanes use the same S-box.
- **Data path.**
  - 128-bit input register, loaded on accept.
  - 128-bit output register, written one chunk at a time.
  - Chunk counter `cnt` of width max(1, log2 N).
- **FSM states:** IDLE, BUSY, DONE.
  - **IDLE:** `o_ready`=1, `o_valid`=0. If `i_valid`=1: capture the words, `i_inverse` and `i_sbox_index`; set `cnt`←0; go to BUSY.
  - **BUSY:** `o_ready`=0, `o_valid`=0. Each cycle, compute slices [cnt·LANES +: LANES] from the input register and write them to the same bit positions of the output register.
    - If `cnt`=N−1, go to DONE.
    - Otherwise `cnt`←`cnt`+1.
  - **DONE:** `o_valid`=1 and `o_ready`=`i_ready`.
    - If `i_ready`=0: hold every output unchanged.
    - If `i_ready`=1 and `i_valid`=1: accept the new block, as in IDLE, and go to BUSY.
    - If `i_ready`=1 and `i_valid`=0: go to IDLE.
- **Input stability.** The captured mode and index are used for the whole block. Changes on `i_inverse`, `i_sbox_index` or the input words while in BUSY or DONE have no effect on the block in flight.
- **Unwritten bits.** Output register bits not yet written in the current block hold their previous values. They are undefined to the consumer because `o_valid`=0.
- **Reset.** While `i_rst`=1 the next state is IDLE, `cnt`=0, and the input and output registers are cleared to 0.
  - Outputs in the cycle after reset: `o_valid`=0, `o_ready`=1, all `o_word_*`=0, `o_data`=0.
  - Outputs while `i_rst` is high: `o_ready`=0.
  - Reset in BUSY or DONE aborts the block silently. No partial result is ever flagged valid.

## Timing
- **Latency.** For a block accepted at edge T, `o_valid` is high from edge T+N. For `LANES`=32 this means `o_valid` is high one cycle after accept.
- **Throughput.** Back-to-back operation with `i_valid`=`i_ready`=1 gives one block per N+1 cycles. The re-accept happens in the DONE cycle, and there is no IDLE bubble.
- **Output timing.**
  - `o_word_*`, `o_data` and `o_valid` are driven directly from registers.
  - `o_ready` is combinational from the state, `i_ready` and `i_rst`.
  - There is no combinational path from `i_valid` to any output.
- **Hold under backpressure.** In DONE with `i_ready`=0, outputs stay stable indefinitely.

## Test plan
- **Forward, zero input.** Reset, then `LANES`=8, forward, k=0, all words 0.
  - Required: `o_valid` rises exactly 4 cycles after accept.
  - Required: `o_word_0`=`o_word_1`=FFFFFFFF, `o_word_2`=`o_word_3`=00000000.
- **Inverse, zero input.** Same stimulus with `i_inverse`=1.
  - Required: `o_word_0`=`o_word_2`=`o_word_3`=FFFFFFFF, `o_word_1`=00000000.
- **Round trip.** Random blocks; for each k=0..7, feed the forward output back with `i_inverse`=1, for every legal `LANES`.
  - Required: output equals the original block.
  - Required: latency equals 32/`LANES` in every case.
- **Backpressure.** `i_ready`=0 for 10 cycles in DONE while the inputs toggle.
  - Required: outputs are unchanged and `o_ready`=0.
  - Then `i_ready`=1 together with `i_valid`=1: the new block is accepted in that same cycle.
- **Reset mid-operation.** Assert `i_rst` during BUSY cycle 2 with `LANES`=4.
  - Required: next cycle `o_valid`=0, `o_ready`=1 and `o_data`=0.
  - Required: the next block then completes correctly.
- **Streaming.** Stream 100 blocks with `i_valid`=`i_ready`=1 and `LANES`=16.
  - Required: exactly one result every 3 cycles, in order, matching the reference model.
